// File: rtl/lenet_layer_sched_pkg.sv
// rtl/lenet_layer_sched_pkg.sv - shared state encoding and layer indices for the LeNet layer scheduler
package lenet_pkg;

    localparam int NUM_LAYERS_DEF = 5;

    localparam int L_CONV1 = 0;
    localparam int L_POOL1 = 1;
    localparam int L_CONV2 = 2;
    localparam int L_POOL2 = 3;
    localparam int L_FC    = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

endpackage

// File: rtl/lenet_layer_sched_if.sv
// rtl/lenet_layer_sched_if.sv - control/status bundle between a pass controller and the layer scheduler
interface lenet_layer_sched_if
    import lenet_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF
);
    logic                  start;
    logic                  abort;
    logic [NUM_LAYERS-1:0] layer_finish;
    logic [NUM_LAYERS-1:0] layer_en;
    logic [NUM_LAYERS-1:0] layer_rst;
    logic [2:0]            cur_layer;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [31:0]           cycle_cnt;

    // Controller side: issues commands, observes scheduler status.
    modport master (
        output start, abort, layer_finish,
        input  layer_en, layer_rst, cur_layer, busy, done, error, cycle_cnt
    );

    // Scheduler side.
    modport slave (
        input  start, abort, layer_finish,
        output layer_en, layer_rst, cur_layer, busy, done, error, cycle_cnt
    );
endinterface

// File: rtl/lenet_layer_sched_timer.sv
// rtl/lenet_layer_sched_timer.sv - per-layer watchdog counter with terminal-count compare
module lenet_layer_timer #(
    parameter int TIMEOUT = 1048576
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);
    localparam int           W    = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    // Clear has priority; increment holds at all-ones so the counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/lenet_layer_sched.sv
// rtl/lenet_layer_sched.sv - sequences LeNet layers through clear/run/gap with timeout and abort
module lenet_layer_sched
    import lenet_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int TIMEOUT    = 1048576
) (
    input  logic                clk,
    input  logic                rst_n,
    lenet_layer_sched_if.slave  bus
);
    localparam logic [2:0]            LAST_IDX = 3'(NUM_LAYERS - 1);
    localparam logic [NUM_LAYERS-1:0] ONE      = NUM_LAYERS'(1);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] idx;
    logic [2:0] idx_nxt;
    logic       launch;
    logic       fin_cur;
    logic       tc;
    logic       timer_clr;
    logic       timer_inc;

    // Only the running layer's finish flag matters; stale flags of other layers are ignored.
    assign fin_cur   = bus.layer_finish[idx];
    assign timer_clr = (state_nxt == S_CLEAR);
    assign timer_inc = (state == S_RUN);

    lenet_layer_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .inc   (timer_inc),
        .tc    (tc)
    );

    // Next-state logic: abort beats everything, finish beats timeout.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        launch    = 1'b0;
        if (bus.abort) begin
            state_nxt = S_IDLE;
            idx_nxt   = 3'd0;
        end else begin
            case (state)
                S_IDLE, S_ERR: begin
                    if (bus.start) begin
                        launch    = 1'b1;
                        state_nxt = S_CLEAR;
                        idx_nxt   = 3'd0;
                    end
                end
                S_CLEAR: state_nxt = S_RUN;
                S_RUN: begin
                    if (fin_cur) begin
                        state_nxt = S_GAP;
                    end else if (tc) begin
                        state_nxt = S_ERR;
                    end
                end
                S_GAP: begin
                    if (idx == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        state_nxt = S_CLEAR;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State, index, run-cycle counter and all outputs registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            idx            <= 3'd0;
            bus.layer_en   <= '0;
            bus.layer_rst  <= '1;
            bus.cur_layer  <= 3'd0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.cycle_cnt  <= 32'd0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            bus.layer_en  <= (state_nxt == S_RUN) ? (ONE << idx_nxt) : '0;
            bus.layer_rst <= bus.abort ? '1 :
                             ((state_nxt == S_CLEAR) ? (ONE << idx_nxt) : '0);
            bus.cur_layer <= (state_nxt == S_IDLE) ? 3'd0 : idx_nxt;
            bus.busy      <= !((state_nxt == S_IDLE) || (state_nxt == S_ERR));
            bus.done      <= (state_nxt == S_DONE);
            if (state_nxt == S_ERR) begin
                bus.error <= 1'b1;
            end else if (launch) begin
                bus.error <= 1'b0;
            end
            if (launch) begin
                bus.cycle_cnt <= 32'd0;
            end else if ((state == S_RUN) && (bus.cycle_cnt != 32'hFFFF_FFFF)) begin
                bus.cycle_cnt <= bus.cycle_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_lenet_layer_sched.sv
// tb/tb_lenet_layer_sched.sv - scoreboard bench for the LeNet layer scheduler
module tb_lenet_layer_sched;
    import lenet_pkg::*;

    localparam int NL = 5;
    localparam int TO = 16;

    typedef struct {
        int          cyc;
        logic [4:0]  en;
        logic [4:0]  rst;
        logic        done;
        logic        err;
        logic        busy;
        logic [2:0]  cur;
        logic [31:0] cnt;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    int   mcnt [NL];
    int   fin_delay [NL];
    ev_t  exp_q [$];

    lenet_layer_sched_if #(.NUM_LAYERS(NL)) bus ();

    lenet_layer_sched #(
        .NUM_LAYERS (NL),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Layer models: count enabled cycles, clear on layer_rst, finish is sticky once count reaches delay.
    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            if (bus.layer_rst[i]) mcnt[i] <= 0;
            else if (bus.layer_en[i]) mcnt[i] <= mcnt[i] + 1;
        end
    end

    always_comb begin
        bus.layer_finish = '0;
        for (int i = 0; i < NL; i++) bus.layer_finish[i] = (mcnt[i] >= fin_delay[i]);
    end

    task automatic push_ev(input int c, input logic [4:0] en, input logic [4:0] rst,
                           input logic done, input logic err, input logic busy,
                           input logic [2:0] cur, input int cnt);
        ev_t e;
        e.cyc = c; e.en = en; e.rst = rst; e.done = done; e.err = err;
        e.busy = busy; e.cur = cur; e.cnt = 32'(cnt);
        exp_q.push_back(e);
    endtask

    // Expected event stream of a pass launched by start seen at cycle t0. With stop_at < NL the
    // stream ends at that layer's RUN entry and c_out is that layer's CLEAR cycle; else c_out is DONE.
    task automatic push_pass(input int t0, input int stop_at, output int cc_out, output int c_out);
        int c;
        int cc;
        int r;
        c  = t0 + 1;
        cc = 0;
        for (int i = 0; i < NL; i++) begin
            r = fin_delay[i] + 1;
            push_ev(c,     5'd0,         5'(1 << i), 1'b0, 1'b0, 1'b1, 3'(i), cc);
            push_ev(c + 1, 5'(1 << i),   5'd0,       1'b0, 1'b0, 1'b1, 3'(i), cc);
            if (i == stop_at) begin
                cc_out = cc;
                c_out  = c;
                return;
            end
            cc = cc + r;
            push_ev(c + 1 + r, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 3'(i), cc);
            c = c + 2 + r;
        end
        push_ev(c,     5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 3'd4, cc);
        push_ev(c + 1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, cc);
        cc_out = cc;
        c_out  = c;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s drain: %0d events still pending after %0d cycles, required 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    // Monitor: every change of the control outputs is an event, popped and compared in order.
    initial begin
        ev_t smp;
        ev_t prv;
        ev_t e;
        prv.en = '0; prv.rst = '1; prv.done = 0; prv.err = 0; prv.busy = 0; prv.cur = '0;
        prv.cnt = '0; prv.cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            smp.cyc = cyc; smp.en = bus.layer_en; smp.rst = bus.layer_rst; smp.done = bus.done;
            smp.err = bus.error; smp.busy = bus.busy; smp.cur = bus.cur_layer; smp.cnt = bus.cycle_cnt;
            if (rst_n && ({smp.en, smp.rst, smp.done, smp.err, smp.busy, smp.cur} !=
                          {prv.en, prv.rst, prv.done, prv.err, prv.busy, prv.cur})) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event cyc=%0d en=%b rst=%b done=%b err=%b busy=%b cur=%0d cnt=%0d, required no event",
                             smp.cyc, smp.en, smp.rst, smp.done, smp.err, smp.busy, smp.cur, smp.cnt);
                end else begin
                    e = exp_q.pop_front();
                    if ({smp.cyc, smp.en, smp.rst, smp.done, smp.err, smp.busy, smp.cur, smp.cnt} !==
                        {e.cyc, e.en, e.rst, e.done, e.err, e.busy, e.cur, e.cnt}) begin
                        failures++;
                        $display("FAIL event got cyc=%0d en=%b rst=%b done=%b err=%b busy=%b cur=%0d cnt=%0d want cyc=%0d en=%b rst=%b done=%b err=%b busy=%b cur=%0d cnt=%0d",
                                 smp.cyc, smp.en, smp.rst, smp.done, smp.err, smp.busy, smp.cur, smp.cnt,
                                 e.cyc, e.en, e.rst, e.done, e.err, e.busy, e.cur, e.cnt);
                    end
                end
            end
            prv = smp;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int t1;
        int cc;
        int cd;
        checks   = 0;
        failures = 0;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int i = 0; i < NL; i++) fin_delay[i] = 9;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_layer_en",  32'(bus.layer_en),  32'h0);
        chk("rst_layer_rst", 32'(bus.layer_rst), 32'h1f);
        chk("rst_busy",      32'(bus.busy),      32'h0);
        chk("rst_done",      32'(bus.done),      32'h0);
        chk("rst_error",     32'(bus.error),     32'h0);
        chk("rst_cur_layer", 32'(bus.cur_layer), 32'h0);
        chk("rst_cycle_cnt", bus.cycle_cnt,      32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        push_ev(cyc + 1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 0);
        drain("reset_release", 5);

        // Normal pass, 10 RUN cycles per layer
        @(negedge clk);
        t0 = cyc; bus.start = 1'b1;
        push_pass(t0, NL, cc, cd);
        @(negedge clk);
        bus.start = 1'b0;
        drain("normal", 200);
        chk("normal_cycle_cnt", bus.cycle_cnt, 32'd50);

        // Start held high: ignored while busy, relaunches from IDLE right after DONE
        @(negedge clk);
        t0 = cyc; bus.start = 1'b1;
        push_pass(t0, NL, cc, cd);
        t1 = cd + 1;
        push_pass(t1, NL, cc, cd);
        while (cyc < t1 + 2) @(negedge clk);
        bus.start = 1'b0;
        drain("held_start", 300);

        // Stale finish flags all high: each layer gets one RUN cycle
        for (int i = 0; i < NL; i++) fin_delay[i] = 0;
        @(negedge clk);
        t0 = cyc; bus.start = 1'b1;
        push_pass(t0, NL, cc, cd);
        @(negedge clk);
        bus.start = 1'b0;
        drain("stale_finish", 100);
        chk("stale_cycle_cnt", bus.cycle_cnt, 32'd5);

        // Finish and timeout in the same cycle: finish wins
        for (int i = 0; i < NL; i++) fin_delay[i] = TO - 1;
        @(negedge clk);
        t0 = cyc; bus.start = 1'b1;
        push_pass(t0, NL, cc, cd);
        @(negedge clk);
        bus.start = 1'b0;
        drain("finish_vs_timeout", 200);
        chk("coincide_cycle_cnt", bus.cycle_cnt, 32'd80);

        // Timeout on layer 2, then restart from ERR
        for (int i = 0; i < NL; i++) fin_delay[i] = 9;
        fin_delay[2] = 1000;
        @(negedge clk);
        t0 = cyc; bus.start = 1'b1;
        push_pass(t0, 2, cc, cd);
        push_ev(cd + 1 + TO, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 3'd2, cc + TO);
        @(negedge clk);
        bus.start = 1'b0;
        drain("timeout", 200);
        chk("err_error",     32'(bus.error),     32'h1);
        chk("err_layer_en",  32'(bus.layer_en),  32'h0);
        chk("err_cur_layer", 32'(bus.cur_layer), 32'h2);
        fin_delay[2] = 9;
        @(negedge clk);
        t0 = cyc; bus.start = 1'b1;
        push_pass(t0, NL, cc, cd);
        @(negedge clk);
        bus.start = 1'b0;
        drain("restart_after_err", 200);

        // Abort in layer 3 RUN with start also high
        @(negedge clk);
        t0 = cyc; bus.start = 1'b1;
        push_pass(t0, 3, cc, cd);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < cd + 5) @(negedge clk);
        bus.abort = 1'b1; bus.start = 1'b1;
        push_ev(cyc + 1, 5'd0, 5'h1f, 1'b0, 1'b0, 1'b0, 3'd0, cc + 5);
        push_ev(cyc + 2, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0, cc + 5);
        @(negedge clk);
        bus.abort = 1'b0; bus.start = 1'b0;
        drain("abort", 100);

        // Asynchronous reset in the middle of layer 1 RUN
        @(negedge clk);
        t0 = cyc; bus.start = 1'b1;
        push_pass(t0, 1, cc, cd);
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < cd + 3) @(negedge clk);
        drain("pre_async", 5);
        #3 rst_n = 1'b0;
        #1;
        chk("async_layer_en",  32'(bus.layer_en),  32'h0);
        chk("async_layer_rst", 32'(bus.layer_rst), 32'h1f);
        chk("async_busy",      32'(bus.busy),      32'h0);
        chk("async_cur_layer", 32'(bus.cur_layer), 32'h0);
        chk("async_cycle_cnt", bus.cycle_cnt,      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push_ev(cyc + 1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 3'd0, 0);
        drain("async_release", 5);

        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
